// File: rtl/race_pkg.sv
// rtl/race_pkg.sv - shared screen encoding and width helper for the LED racer controller
package race_pkg;

  typedef enum logic [1:0] {
    SCR_MENU = 2'd0,
    SCR_RACE = 2'd1,
    SCR_END  = 2'd2
  } screen_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/race_phase_timer.sv
// rtl/race_phase_timer.sv - clearable phase counter with a run-time terminal count
module race_phase_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;

  // Clear has priority over counting so a restart in the same cycle wins.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign done = enable && (count == limit);

endmodule

// File: rtl/race_game_ctrl.sv
// rtl/race_game_ctrl.sv - MENU/RACE/END game-state controller for NUM_PLAYERS racers
module race_game_ctrl
  import race_pkg::*;
#(
  parameter int NUM_PLAYERS          = 4,
  parameter int MAX_POS              = 109,
  parameter int POS_W                = width_of(MAX_POS + 1),
  parameter int MENU_TIMER_CLK_COUNT = 10,
  parameter int END_TIMER_CLK_COUNT  = 20,
  parameter int IDX_W                = width_of(NUM_PLAYERS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_PLAYERS-1:0]       btn_pulse,
  output logic [1:0]                   screen,
  output logic [NUM_PLAYERS-1:0]       ready,
  output logic [NUM_PLAYERS*POS_W-1:0] pos_flat,
  output logic [IDX_W-1:0]             winner,
  output logic                         winner_valid,
  output logic                         update_frame
);

  localparam int TMR_MAX = (MENU_TIMER_CLK_COUNT > END_TIMER_CLK_COUNT) ?
                           MENU_TIMER_CLK_COUNT : END_TIMER_CLK_COUNT;
  localparam int TMR_W = width_of(TMR_MAX);
  localparam logic [TMR_W-1:0] MENU_LAST = TMR_W'(MENU_TIMER_CLK_COUNT - 1);
  localparam logic [TMR_W-1:0] END_LAST  = TMR_W'(END_TIMER_CLK_COUNT - 1);
  localparam logic [POS_W-1:0] POS_MAX   = POS_W'(MAX_POS);
  localparam logic [POS_W-1:0] POS_PRE   = POS_W'(MAX_POS - 1);

  screen_t                scr_q;
  logic                   in_menu, in_race, in_end;
  logic [NUM_PLAYERS-1:0] new_ready, pos_inc, reached;
  logic                   menu_expire, end_expire, any_reach;
  logic                   tmr_clear, tmr_enable, tmr_done;
  logic [TMR_W-1:0]       tmr_limit;
  logic                   frame_change, change_q;
  logic [IDX_W-1:0]       win_idx;

  assign in_menu = (scr_q == SCR_MENU);
  assign in_race = (scr_q == SCR_RACE);
  assign in_end  = (scr_q == SCR_END);

  // Only players not yet ready can join; repeat presses must not restart the countdown.
  assign new_ready   = in_menu ? (btn_pulse & ~ready) : '0;
  assign menu_expire = in_menu && tmr_done && (new_ready == '0);
  assign end_expire  = in_end && tmr_done;
  assign any_reach   = |reached;

  // One timer serves both the MENU countdown and the END hold.
  assign tmr_clear  = (|new_ready) | menu_expire | any_reach | end_expire;
  assign tmr_enable = (in_menu && (|ready)) || in_end;
  assign tmr_limit  = in_end ? END_LAST : MENU_LAST;

  race_phase_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (tmr_clear),
    .enable(tmr_enable),
    .limit (tmr_limit),
    .done  (tmr_done)
  );

  // Any visible change: screen, a ready flag or a position.
  assign frame_change = (|new_ready) | menu_expire | (|pos_inc) | end_expire;

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
    logic             rdy_r;
    logic [POS_W-1:0] pos_r;

    assign pos_inc[gi] = in_race && btn_pulse[gi] && rdy_r && (pos_r != POS_MAX);
    assign reached[gi] = pos_inc[gi] && (pos_r == POS_PRE);
    assign ready[gi]   = rdy_r;
    assign pos_flat[gi*POS_W +: POS_W] = pos_r;

    // Per-player join flag and saturating position, wiped when the END screen times out.
    always_ff @(posedge clk) begin
      if (rst || end_expire) begin
        rdy_r <= 1'b0;
        pos_r <= '0;
      end else begin
        if (new_ready[gi]) rdy_r <= 1'b1;
        if (pos_inc[gi])   pos_r <= pos_r + 1'b1;
      end
    end
  end

  // Lowest-numbered player that hits the finish on this edge takes the win.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (reached[i]) win_idx = IDX_W'(i);
    end
  end

  // Screen FSM plus the delayed redraw request; reset primes an initial draw.
  always_ff @(posedge clk) begin
    if (rst) begin
      scr_q        <= SCR_MENU;
      winner       <= '0;
      winner_valid <= 1'b0;
      change_q     <= 1'b1;
      update_frame <= 1'b0;
    end else begin
      change_q     <= frame_change;
      update_frame <= change_q;
      case (scr_q)
        SCR_MENU: if (menu_expire) scr_q <= SCR_RACE;
        SCR_RACE: begin
          if (any_reach) begin
            scr_q        <= SCR_END;
            winner       <= win_idx;
            winner_valid <= 1'b1;
          end
        end
        SCR_END: begin
          if (end_expire) begin
            scr_q        <= SCR_MENU;
            winner       <= '0;
            winner_valid <= 1'b0;
          end
        end
        default: scr_q <= SCR_MENU;
      endcase
    end
  end

  assign screen = scr_q;

endmodule

// File: tb/tb_race_game_ctrl.sv
// tb/tb_race_game_ctrl.sv - scoreboard bench for race_game_ctrl with a behavioural game model
module tb_race_game_ctrl;

  localparam int NP = 4;
  localparam int MP = 5;
  localparam int PW = 3;
  localparam int IW = 2;
  localparam int MT = 10;
  localparam int ET = 20;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NP-1:0]      btn = '0;
  logic [1:0]         screen;
  logic [NP-1:0]      ready;
  logic [NP*PW-1:0]   pos_flat;
  logic [IW-1:0]      winner;
  logic               winner_valid;
  logic               update_frame;

  race_game_ctrl #(
    .NUM_PLAYERS(NP),
    .MAX_POS(MP),
    .MENU_TIMER_CLK_COUNT(MT),
    .END_TIMER_CLK_COUNT(ET)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_pulse(btn),
    .screen(screen),
    .ready(ready),
    .pos_flat(pos_flat),
    .winner(winner),
    .winner_valid(winner_valid),
    .update_frame(update_frame)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       scr;
    logic [NP-1:0]    rdy;
    logic [NP*PW-1:0] pos;
    logic [IW-1:0]    win;
    logic             wv;
  } snap_t;

  typedef struct packed {
    int    cyc;
    snap_t s;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  int    pcyc = 0;
  snap_t prev_out;
  bit    chk_rst = 1'b0;

  // reference game state: 0=menu 1=race 2=end
  int m_scr;
  int m_rdy[NP];
  int m_pos[NP];
  int m_win;
  int m_wv;
  int m_tmr;
  bit m_chg_prev;

  always @(posedge clk) pcyc <= pcyc + 1;

  function automatic snap_t model_snap();
    snap_t s;
    s.scr = 2'(m_scr);
    for (int i = 0; i < NP; i++) begin
      s.rdy[i] = (m_rdy[i] != 0);
      s.pos[i*PW +: PW] = PW'(m_pos[i]);
    end
    s.win = IW'(m_win);
    s.wv  = (m_wv != 0);
    return s;
  endfunction

  task automatic model_reset();
    m_scr = 0; m_win = 0; m_wv = 0; m_tmr = 0;
    for (int i = 0; i < NP; i++) begin
      m_rdy[i] = 0;
      m_pos[i] = 0;
    end
  endtask

  task automatic model_step(input logic [NP-1:0] b, input logic r, input int edge_idx);
    exp_t e;
    bit   chg;
    int   nrdy;
    int   nready_cnt;
    int   w;
    if (!r && m_chg_prev) begin
      e.cyc = edge_idx;
      e.s   = model_snap();
      sb.push_back(e);
    end
    if (r) begin
      model_reset();
      m_chg_prev = 1'b1;
      return;
    end
    chg = 1'b0;
    if (m_scr == 0) begin
      nrdy = 0;
      nready_cnt = 0;
      for (int i = 0; i < NP; i++) begin
        if (m_rdy[i] != 0) nready_cnt++;
        if (b[i] && m_rdy[i] == 0) begin
          m_rdy[i] = 1;
          nrdy++;
        end
      end
      if (nrdy > 0) begin
        m_tmr = 0;
        chg = 1'b1;
      end else if (nready_cnt > 0) begin
        if (m_tmr == MT - 1) begin
          m_scr = 1;
          m_tmr = 0;
          chg = 1'b1;
        end else begin
          m_tmr++;
        end
      end
    end else if (m_scr == 1) begin
      w = -1;
      for (int i = 0; i < NP; i++) begin
        if (b[i] && m_rdy[i] != 0 && m_pos[i] < MP) begin
          m_pos[i]++;
          chg = 1'b1;
        end
      end
      for (int i = NP - 1; i >= 0; i--) if (m_pos[i] == MP) w = i;
      if (w >= 0) begin
        m_win = w;
        m_wv  = 1;
        m_scr = 2;
        m_tmr = 0;
      end
    end else begin
      if (m_tmr == ET - 1) begin
        model_reset();
        chg = 1'b1;
      end else begin
        m_tmr++;
      end
    end
    m_chg_prev = chg;
  endtask

  // monitor: every redraw pulse must match the next queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0 && sb[0].cyc < pcyc) begin
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL uf_missing: expected update_frame at cycle %0d, no pulse by cycle %0d", e.cyc, pcyc);
    end
    if (update_frame === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL uf_unexpected: update_frame at cycle %0d, required none", pcyc);
      end else begin
        e = sb.pop_front();
        checks++;
        if (e.cyc != pcyc) begin
          failures++;
          $display("FAIL uf_timing: got pulse at cycle %0d, required cycle %0d", pcyc, e.cyc);
        end
        checks++;
        if (prev_out !== e.s) begin
          failures++;
          $display("FAIL uf_state: got scr=%0d rdy=%b pos=%h win=%0d wv=%0d, required scr=%0d rdy=%b pos=%h win=%0d wv=%0d",
                   prev_out.scr, prev_out.rdy, prev_out.pos, prev_out.win, prev_out.wv,
                   e.s.scr, e.s.rdy, e.s.pos, e.s.win, e.s.wv);
        end
      end
    end
    prev_out = {screen, ready, pos_flat, winner, winner_valid};
  end

  task automatic cycle(input logic [NP-1:0] b, input logic r);
    @(negedge clk);
    if (chk_rst) begin
      checks++;
      if ({screen, ready, pos_flat, winner, winner_valid, update_frame} !== '0) begin
        failures++;
        $display("FAIL reset_state: got scr=%0d rdy=%b pos=%h win=%0d wv=%0d uf=%0d, required all 0",
                 screen, ready, pos_flat, winner, winner_valid, update_frame);
      end
      chk_rst = 1'b0;
    end
    btn = b;
    rst = r;
    model_step(b, r, pcyc + 1);
    if (r) chk_rst = 1'b1;
  endtask

  initial begin
    logic [NP-1:0] rb;
    logic          rr;
    model_reset();
    m_chg_prev = 1'b1;
    chk_rst = 1'b1;

    repeat (2) cycle('0, 1'b1);
    repeat (3) cycle('0, 1'b0);

    // join: p0 at t=0, p2 at t=5, repeat p0 at t=7
    cycle(4'b0001, 1'b0);
    repeat (4) cycle('0, 1'b0);
    cycle(4'b0100, 1'b0);
    cycle('0, 1'b0);
    cycle(4'b0001, 1'b0);
    repeat (14) cycle('0, 1'b0);

    // race: non-ready p1 ignored, p0 spaced, p2 back-to-back, joint finish
    repeat (3) begin cycle(4'b0010, 1'b0); cycle('0, 1'b0); end
    repeat (4) begin cycle(4'b0001, 1'b0); cycle('0, 1'b0); end
    repeat (4) cycle(4'b0100, 1'b0);
    cycle(4'b0101, 1'b0);

    // end screen ignores presses, then returns to menu
    repeat (3) cycle(4'b1111, 1'b0);
    repeat (25) cycle('0, 1'b0);

    // reset in the middle of a race
    cycle(4'b0001, 1'b0);
    repeat (12) cycle('0, 1'b0);
    repeat (3) cycle(4'b0001, 1'b0);
    cycle('0, 1'b1);
    repeat (3) cycle('0, 1'b0);

    // random play
    for (int n = 0; n < 3000; n++) begin
      rr = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NP; i++) rb[i] = ($urandom_range(0, 2) == 0);
      cycle(rb, rr);
    end

    repeat (40) cycle('0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
